// File: rtl/peri_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: 4-entry byte FIFO, TXD/STATUS registers,
// frame-complete flag with level interrupt.
module peri_uart_tx #(
  parameter logic [31:0] BASE     = 32'h4000_0018,
  parameter int          BAUD_DIV = 5208
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        TX,
  output logic        irq
);

  localparam logic [31:0] STAT_ADDR = BASE + 32'd4;
  localparam logic [15:0] BAUD_MAX  = 16'(BAUD_DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t      state;
  logic [7:0]  fifo [4];
  logic [1:0]  wptr, rptr;
  logic [2:0]  count;
  logic [7:0]  shift;
  logic [2:0]  bit_idx;
  logic [15:0] baud;
  logic        done, overflow, irq_en;

  logic push_req, stat_wr, full, empty, baud_end, pop, push_ok, busy;
  logic [7:0] head;

  assign push_req = wr && (addr == BASE);
  assign stat_wr  = wr && (addr == STAT_ADDR);
  assign full     = (count == 3'd4);
  assign empty    = (count == 3'd0);
  assign baud_end = (baud == BAUD_MAX);
  assign busy     = (state != IDLE);
  assign head     = fifo[rptr];
  // Fullness uses the pre-edge count, so a push alongside a pop while full is dropped.
  assign push_ok  = push_req && !full;
  assign pop      = !empty && (state == IDLE || (state == STOP && baud_end));
  assign irq      = irq_en & done;

  always_ff @(posedge clk) begin
    if (push_ok) fifo[wptr] <= wdata[7:0];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
      irq_en   <= 1'b0;
    end else begin
      if (push_ok) wptr <= wptr + 2'd1;
      if (pop)     rptr <= rptr + 2'd1;
      case ({push_ok, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: ;
      endcase
      if (push_req && full)        overflow <= 1'b1;
      else if (stat_wr && wdata[4]) overflow <= 1'b0;
      if (stat_wr) irq_en <= wdata[5];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      TX      <= 1'b1;
      shift   <= '0;
      bit_idx <= '0;
      baud    <= '0;
      done    <= 1'b0;
    end else begin
      // Clear first so a completion in the same cycle overrides it.
      if (stat_wr && wdata[3]) done <= 1'b0;
      case (state)
        IDLE: begin
          TX <= 1'b1;
          if (pop) begin
            shift   <= head;
            bit_idx <= '0;
            baud    <= '0;
            TX      <= 1'b0;
            state   <= START;
          end
        end
        START: begin
          if (baud_end) begin
            baud  <= '0;
            TX    <= shift[0];
            state <= DATA;
          end else baud <= baud + 16'd1;
        end
        DATA: begin
          if (baud_end) begin
            baud <= '0;
            if (bit_idx == 3'd7) begin
              TX    <= 1'b1;
              state <= STOP;
            end else begin
              shift   <= shift >> 1;
              bit_idx <= bit_idx + 3'd1;
              TX      <= shift[1];
            end
          end else baud <= baud + 16'd1;
        end
        STOP: begin
          if (baud_end) begin
            baud <= '0;
            if (pop) begin
              shift   <= head;
              bit_idx <= '0;
              TX      <= 1'b0;
              state   <= START;
            end else begin
              state <= IDLE;
              done  <= 1'b1;
            end
          end else baud <= baud + 16'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    rdata = '0;
    if (rd && addr == STAT_ADDR)
      rdata = {21'b0, count, 2'b0, irq_en, overflow, done, busy, full, empty};
  end

endmodule

// File: tb/tb_peri_uart_tx.sv
// Randomized self-checking bench for peri_uart_tx; expected line waveforms come
// from the 8N1 frame definition applied to the bytes written.
module tb_peri_uart_tx;
  localparam int          BD   = 4;
  localparam logic [31:0] BASE = 32'h4000_0018;
  localparam logic [31:0] STAT = BASE + 32'd4;

  logic        clk = 1'b0, reset = 1'b0, rd = 1'b0, wr = 1'b0;
  logic [31:0] addr = '0, wdata = '0, rdata;
  logic        tx, irq;
  int          checks = 0, failures = 0;
  logic [7:0]  bb [6];

  always #5 clk = ~clk;

  peri_uart_tx #(.BASE(BASE), .BAUD_DIV(BD)) dut (
    .clk(clk), .reset(reset), .rd(rd), .wr(wr), .addr(addr),
    .wdata(wdata), .rdata(rdata), .TX(tx), .irq(irq)
  );

  // Frame bit k of an 8N1 frame: start, 8 data bits LSB first, stop.
  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return b[k-1];
  endfunction

  // Samples n=0..42: idle before and at the write edge, 40 frame cycles, idle after.
  function automatic logic [42:0] exp_single(input logic [7:0] b);
    logic [42:0] e;
    for (int n = 0; n < 43; n++)
      e[n] = (n < 2 || n >= 42) ? 1'b1 : frame_bit(b, (n - 2) / BD);
    return e;
  endfunction

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    addr = a; wdata = d; wr = 1'b1;
    @(posedge clk);
    #1 wr = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    addr = a; rd = 1'b1;
    #1 d = rdata;
    rd = 1'b0;
  endtask

  task automatic send_capture(input logic [7:0] b, output logic [42:0] otx,
                              output logic [42:0] oirq);
    for (int n = 0; n < 43; n++) begin
      @(negedge clk);
      otx[n] = tx; oirq[n] = irq;
      if (n == 0) begin addr = BASE; wdata = {24'h0, b}; wr = 1'b1; end
      else wr = 1'b0;
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    checks++; if (tx !== 1'b1) begin failures++; $display("FAIL reset_tx got=%b exp=1", tx); end
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", irq); end
    bus_read(STAT, d);
    checks++; if (d !== 32'h1) begin failures++; $display("FAIL reset_status got=%h exp=00000001", d); end
  endtask

  task automatic test_single();
    logic [42:0] otx, oirq;
    logic [31:0] d;
    send_capture(8'hA5, otx, oirq);
    checks++; if (otx !== exp_single(8'hA5)) begin
      failures++; $display("FAIL single_frame got=%h exp=%h", otx, exp_single(8'hA5)); end
    bus_read(STAT, d);
    checks++; if (d !== 32'h9) begin failures++; $display("FAIL single_status got=%h exp=00000009", d); end
  endtask

  task automatic test_random_bytes();
    logic [42:0] otx, oirq;
    logic [31:0] d;
    logic [7:0]  b;
    repeat (4) begin
      b = 8'($urandom);
      send_capture(b, otx, oirq);
      checks++; if (otx !== exp_single(b)) begin
        failures++; $display("FAIL rand_frame byte=%h got=%h exp=%h", b, otx, exp_single(b)); end
      bus_read(STAT, d);
      checks++; if (d !== 32'h9) begin failures++; $display("FAIL rand_status got=%h exp=00000009", d); end
    end
  endtask

  task automatic test_interrupt();
    logic [42:0] otx, oirq;
    logic [31:0] d;
    logic [7:0]  b;
    bus_write(STAT, 32'h28);
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_enable_idle got=%b exp=0", irq); end
    b = 8'($urandom);
    send_capture(b, otx, oirq);
    checks++; if (otx !== exp_single(b)) begin
      failures++; $display("FAIL irq_frame got=%h exp=%h", otx, exp_single(b)); end
    checks++; if (oirq !== (43'h1 << 42)) begin
      failures++; $display("FAIL irq_timing got=%h exp=%h", oirq, 43'h1 << 42); end
    bus_write(STAT, 32'h28);
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_clear got=%b exp=0", irq); end
    bus_read(STAT, d);
    checks++; if (d !== 32'h21) begin failures++; $display("FAIL irq_status got=%h exp=00000021", d); end
    bus_write(STAT, 32'h0);
  endtask

  task automatic test_back_to_back();
    logic [203:0] obs, ex;
    logic [31:0]  d, dmid;
    for (int i = 0; i < 6; i++) bb[i] = 8'($urandom);
    dmid = '0;
    for (int n = 0; n < 204; n++) begin
      @(negedge clk);
      obs[n] = tx;
      rd = 1'b0;
      if (n < 6) begin addr = BASE; wdata = {24'h0, bb[n]}; wr = 1'b1; end
      else begin
        wr = 1'b0;
        if (n == 6) begin addr = STAT; rd = 1'b1; #1 dmid = rdata; end
      end
    end
    rd = 1'b0;
    for (int n = 0; n < 204; n++)
      ex[n] = (n < 2 || n >= 202) ? 1'b1
            : frame_bit(bb[(n - 2) / (10 * BD)], ((n - 2) % (10 * BD)) / BD);
    checks++; if (dmid !== 32'h416) begin
      failures++; $display("FAIL burst_overflow_status got=%h exp=00000416", dmid); end
    checks++; if (obs !== ex) begin
      failures++; $display("FAIL burst_stream got=%h exp=%h", obs, ex); end
    bus_read(STAT, d);
    checks++; if (d !== 32'h19) begin failures++; $display("FAIL burst_end_status got=%h exp=00000019", d); end
    bus_write(STAT, 32'h18);
    bus_read(STAT, d);
    checks++; if (d !== 32'h1) begin failures++; $display("FAIL burst_clear_status got=%h exp=00000001", d); end
  endtask

  task automatic test_reset_midframe();
    logic [7:0]  b0;
    logic [31:0] d;
    logic        stayed_idle;
    b0 = 8'($urandom);
    bus_write(BASE, {24'h0, b0});
    bus_write(BASE, 32'($urandom) & 32'hFF);
    bus_write(BASE, 32'($urandom) & 32'hFF);
    repeat (16) @(negedge clk);
    checks++; if (tx !== b0[3]) begin failures++; $display("FAIL midframe_bit3 got=%b exp=%b", tx, b0[3]); end
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    checks++; if (tx !== 1'b1) begin failures++; $display("FAIL midframe_tx_after_reset got=%b exp=1", tx); end
    stayed_idle = 1'b1;
    repeat (80) begin @(negedge clk); if (tx !== 1'b1) stayed_idle = 1'b0; end
    checks++; if (stayed_idle !== 1'b1) begin failures++; $display("FAIL midframe_queued_sent got=0 exp=1"); end
    bus_read(STAT, d);
    checks++; if (d !== 32'h1) begin failures++; $display("FAIL midframe_status got=%h exp=00000001", d); end
  endtask

  task automatic test_decode();
    logic [31:0] d;
    logic        stayed_idle;
    bus_write(BASE + 32'd8, 32'h3F);
    bus_write(BASE - 32'd4, 32'h3F);
    bus_write(BASE - 32'd4, 32'h5A);
    stayed_idle = 1'b1;
    repeat (20) begin @(negedge clk); if (tx !== 1'b1) stayed_idle = 1'b0; end
    checks++; if (stayed_idle !== 1'b1) begin failures++; $display("FAIL decode_tx_idle got=0 exp=1"); end
    bus_read(STAT, d);
    checks++; if (d !== 32'h1) begin failures++; $display("FAIL decode_status got=%h exp=00000001", d); end
    bus_read(BASE + 32'd8, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL decode_read_plus8 got=%h exp=0", d); end
    bus_read(BASE - 32'd4, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL decode_read_minus4 got=%h exp=0", d); end
    bus_read(BASE, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL decode_read_txd got=%h exp=0", d); end
    @(negedge clk);
    addr = STAT; rd = 1'b0;
    #1;
    checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL decode_rd_low got=%h exp=0", rdata); end
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL decode_irq got=%b exp=0", irq); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_random_bytes();
    test_interrupt();
    test_back_to_back();
    test_reset_midframe();
    test_decode();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/peri_uart_tx.md
# peri_uart_tx

Memory-mapped UART transmitter on the CPU peripheral bus (region at and above 0x4000_0000). The CPU is the bus initiator; this block is the responder. It accepts bytes written by the CPU into a 4-entry FIFO and serialises them as 8N1 frames on `TX`. A status register and a level interrupt report completion.

## Interface
- `BASE`, 32'h4000_0018: byte address of TXD register; STATUS at `BASE+4`.
- `BAUD_DIV`, 5208: `clk` cycles per bit (50 MHz / 9600); legal range 2..65535.
- `clk`  input  1  system clock; everything is on the rising edge.
- `reset`  input  1  synchronous, active-low; sampled on the rising edge of `clk`.
- `rd`  input  1  read strobe; address decode is combined with it.
- `wr`  input  1  write strobe, sampled on the rising edge of `clk`.
- `addr`  input  32  full byte address, compared exactly against `BASE` / `BASE+4`.
- `wdata`  input  32  write data.
- `rdata`  output  32  read data. Combinational. 0 when `rd`=0 or the address does not match.
- `TX`  output  1  serial line, idle high.
- `irq`  output  1  level interrupt, equal to `irq_en & done`.

## Operation
**Registers**
- TXD write: pushes `wdata[7:0]`.
- TXD read: returns 0.
- STATUS read: {21'b0, count[2:0] at [10:8], 2'b0, irq_en[5], overflow[4], done[3], busy[2], full[1], empty[0]}.
- STATUS write:
  - `wdata[5]` loads `irq_en`.
  - `wdata[3]`=1 clears `done`.
  - `wdata[4]`=1 clears `overflow`.
  - Other bits are ignored.
- Reads have no side effects.

**FIFO**
- Depth 4, with a 3-bit `count` (0..4) and wrap-around read/write pointers.
- Push when count==4: the byte is dropped and `overflow` is set (sticky).
- Fullness is judged on the pre-edge count. A push in the same cycle as a pop while full is still dropped.
- Simultaneous push and pop with count 1..3: count is unchanged and both take effect.

**FSM**
- States: IDLE, START, DATA, STOP.
  - IDLE: `TX`=1. If the FIFO is non-empty, pop the head into the shift register, load the bit counter to 0 and the baud counter to 0, then go to START.
  - START: `TX`=0 for `BAUD_DIV` cycles, then go to DATA.
  - DATA: `TX`=shift[0] (LSB first). Every `BAUD_DIV` cycles, shift right and increment the bit index. After bit 7 completes, go to STOP.
  - STOP: `TX`=1 for `BAUD_DIV` cycles. At the end, if the FIFO is non-empty, pop and go directly to START (no idle gap). Otherwise go to IDLE and set `done`.
- The baud counter runs 0..`BAUD_DIV`-1 and wraps.
- `busy` = (state != IDLE).
- If `done` set and a STATUS clear happen in the same cycle, set wins.

**Reset** (`reset`=0 at an edge) applies in any state, including mid-frame:
- FIFO emptied, state to IDLE, `TX`=1 from the next edge.
- `done`, `overflow` and `irq_en` cleared, so `irq`=0.
- Counters zeroed.
- The partial frame is abandoned with no completion.

## Timing
- `TX` is a registered output.
- TXD write at edge N into an empty FIFO with the FSM in IDLE:
  - FIFO non-empty after edge N.
  - Pop at edge N+1; `TX` falls after edge N+1.
- Frame length is exactly 10×`BAUD_DIV` cycles, start-bit falling edge to the end of the stop bit.
- Back-to-back frames: the next start bit begins on the cycle immediately after the last stop-bit cycle.
- `done` and `irq` rise on the edge that ends the last stop bit.
- `rdata` is valid in the same cycle as `rd`/`addr` (single-cycle CPU load).
- A write is visible in STATUS from the cycle after its edge.

## Test plan
All scenarios use `BAUD_DIV`=4.
- **Reset values:** hold `reset`=0 for 2 cycles. Then `TX`=1 and `irq`=0. Reading STATUS returns 0x0000_0001 (empty).
- **Single byte:** write 0xA5 to TXD. `TX` falls 1 cycle after the write edge. Line sequence is 0,1,0,1,0,0,1,0,1,1, each held 4 cycles (40 cycles total). After that STATUS=0x0000_0009 (done, empty).
- **Burst and overflow:** write 0x01, 0x02, 0x03, 0x04, 0x05, 0x06 on consecutive cycles.
  - The first byte is popped immediately, so the FIFO holds 4. The sixth write sets `overflow`, making STATUS bit4=1.
  - Five contiguous frames (0x01..0x05) follow with no idle gap, 200 cycles in total.
- **Interrupt:** write STATUS 0x20, then send one byte. `irq` rises at the end of the stop bit. Writing STATUS 0x28 drops `irq` next cycle while `irq_en` stays 1.
- **Reset mid-frame:** assert `reset` during DATA bit 3. `TX`=1 next cycle and stays idle. STATUS=0x0000_0001. Bytes that were queued are not sent.
- **Decode isolation:** reads and writes at `BASE+8` and `BASE-4` have no effect, and `rdata`=0 for them. `rdata`=0 whenever `rd`=0, even with a matching address.
